// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shared adder serves both shift-add multiply and restoring divide.
// Every op takes WIDTH+2 edges from the start edge to the done pulse.
// Optional feature: define MULDIV_MTHI_MTLO_EN to add the MTHI/MTLO write ports
// hi_we, lo_we and wr_data. Writes are honoured only in IDLE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
`ifdef MULDIV_MTHI_MTLO_EN
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;       // op[1]: divide, op[0]: unsigned
  logic [WIDTH-1:0]   r_a;        // raw dividend, kept for the divide-by-zero result
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_p_hi;     // product high half / partial remainder
  logic [WIDTH-1:0]   r_p_lo;     // multiplier bits / dividend bits becoming quotient
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH+1:0]   w_add_a;
  logic [WIDTH+1:0]   w_add_b;
  logic [WIDTH+1:0]   w_cin;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_quo_neg;
  logic [WIDTH-1:0]   w_rem_neg;

  // Operand magnitudes for PREP and sign-corrected results for FIX.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_signed   = ~r_op[0];
    w_a_mag    = r_a;
    w_b_mag    = r_b;
    if (w_signed && r_a[WIDTH-1]) w_a_mag = {WIDTH{1'b0}} - r_a;
    if (w_signed && r_b[WIDTH-1]) w_b_mag = {WIDTH{1'b0}} - r_b;
    w_prod_neg = {(2*WIDTH){1'b0}} - {r_p_hi, r_p_lo};
    w_quo_neg  = {WIDTH{1'b0}} - r_p_lo;
    w_rem_neg  = {WIDTH{1'b0}} - r_p_hi;
  end

  // Shared adder: adds the multiplicand, or subtracts the divisor from the shifted remainder.
  always_comb begin
    w_add_a = {2'b00, r_p_hi};
    w_add_b = {2'b00, r_m};
    w_cin   = '0;
    if (r_op[1]) begin
      w_add_a = {1'b0, r_p_hi, r_p_lo[WIDTH-1]};
      w_add_b = ~{2'b00, r_m};
      w_cin   = {{(WIDTH+1){1'b0}}, 1'b1};
    end
    w_sum = w_add_a + w_add_b + w_cin;
  end

  // Sequencer FSM with datapath and registered outputs; flush outranks all other work.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_m        <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
`ifdef MULDIV_MTHI_MTLO_EN
            if (hi_we) r_hi <= wr_data;
            if (lo_we) r_lo <= wr_data;
`endif
            if (start && !flush) begin
              r_state    <= S_PREP;
              r_busy     <= 1'b1;
              r_op       <= op;
              r_a        <= operand_a;
              r_b        <= operand_b;
              r_div_zero <= 1'b0;
            end
          end
          S_PREP: begin
            r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_rem <= w_signed & r_a[WIDTH-1];
            r_b_zero  <= (r_b == '0);
            r_p_hi    <= '0;
            if (r_op[1]) begin
              r_m    <= w_b_mag;
              r_p_lo <= w_a_mag;
            end else begin
              r_m    <= w_a_mag;
              r_p_lo <= w_b_mag;
            end
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= S_CALC;
          end
          S_CALC: begin
            if (r_op[1]) begin
              // Restoring divide: keep the difference only when it did not go negative.
              if (!w_sum[WIDTH+1]) begin
                r_p_hi <= w_sum[WIDTH-1:0];
                r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b1};
              end else begin
                r_p_hi <= w_add_a[WIDTH-1:0];
                r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b0};
              end
            end else if (r_p_lo[0]) begin
              {r_p_hi, r_p_lo} <= {w_sum[WIDTH:0], r_p_lo[WIDTH-1:1]};
            end else begin
              {r_p_hi, r_p_lo} <= {1'b0, r_p_hi, r_p_lo[WIDTH-1:1]};
            end
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - CW'(1);
          end
          S_FIX: begin
            if (!r_op[1]) begin
              {r_hi, r_lo} <= r_neg_res ? w_prod_neg : {r_p_hi, r_p_lo};
            end else if (r_b_zero) begin
              // Divide by zero reports the raw dividend, bypassing sign correction.
              r_hi       <= r_a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else begin
              r_lo <= r_neg_res ? w_quo_neg : r_p_lo;
              r_hi <= r_neg_rem ? w_rem_neg : r_p_hi;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles using a single shared shift-add/subtract datapath, and writes the HI/LO result registers. It sits beside the ALU in the EX stage. The hazard unit holds the pipeline on `busy` so that MFHI/MFLO read a completed result.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  WIDTH  rs value (multiplicand or dividend).
- `operand_b`  in  WIDTH  rt value (multiplier or divisor).
- `flush`  in  1  synchronous abort (branch mispredict or exception).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have been updated.
- `div_zero`  out  1  set when a DIV/DIVU completes with `operand_b == 0`.
- `hi`  out  WIDTH  HI register: upper product word, or remainder.
- `lo`  out  WIDTH  LO register: lower product word, or quotient.

## Operation
States:
- IDLE → PREP on `start & ~flush`. At this edge `op` and the operands are latched and `div_zero` is cleared.
- PREP (1 cycle):
  - For signed ops, take absolute values of both operands and record the result sign.
  - For DIV, also record the dividend sign for the remainder.
  - Load the iteration counter with `WIDTH-1`.
- CALC (`WIDTH` cycles): one iteration per cycle.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - The counter decrements each cycle; at counter 0 the state moves to FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Write `hi`/`lo` and set `div_zero` if this was a divide by zero.
  - Pulse `done` and return to IDLE.

Arithmetic:
- MULT/MULTU produce the full `2*WIDTH` product as {hi, lo}.
- DIV truncates the quotient toward zero; the remainder takes the sign of the dividend.
- Most-negative ÷ −1 wraps: lo = 0x80000000, hi = 0.
- Divide by zero, signed or unsigned: lo = all ones, hi = `operand_a` unmodified (sign correction is bypassed), `div_zero` = 1.
- `div_zero` holds until the next accepted `start`.

Boundary conditions:
- `start` outside IDLE is ignored; no queueing.
- `flush` in PREP, CALC or FIX:
  - The next edge returns to IDLE.
  - `busy` falls; `done` is not pulsed.
  - `hi`, `lo` and `div_zero` are unchanged.
- `flush` together with `start` in IDLE: flush wins and the start is dropped.
- A `start` in the cycle where `done` is high is accepted, because the state is already IDLE.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `div_zero` 0, `hi` 0, `lo` 0. Reset is applied asynchronously and is valid mid-operation.
- The start edge is E0.
  - `busy` = 1 from E0 through E`WIDTH+1`.
  - At E`WIDTH+2`: `hi`/`lo` are updated, `done` = 1 for one cycle, and `busy` = 0.
  - Total latency is `WIDTH+2` edges (34 for `WIDTH` = 32), identical for every op, including divide by zero.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `MULDIV_MTHI_MTLO_EN` defined:
  - Adds ports `hi_we` in 1, `lo_we` in 1, and `wr_data` in WIDTH, for MTHI/MTLO.
  - In IDLE, a write updates the selected register at the next edge.
  - Writes while `busy` are ignored.
  - A write together with `start` takes effect; the result produced by that start later overwrites it.
- `MULDIV_MTHI_MTLO_EN` undefined: these ports are absent, and HI/LO change only via FIX or reset.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; `done` exactly 34 edges after the start edge, `busy` high for the 34 cycles before it.
- MULT 0xFFFFFFFD (−3) × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- Signed divides:
  - DIV −7 ÷ 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 100 ÷ 0 → lo = 0xFFFFFFFF, hi = 100, `div_zero` = 1. A following MULTU start clears `div_zero` at the start edge.
- Start contention and flush:
  - Assert `start` at CALC cycle 5: it is ignored and the result matches a single operation.
  - Assert `flush` at CALC cycle 10: `busy` = 0 next edge, no `done`, hi/lo keep prior values.
- Assert `reset_n` low mid-CALC: all outputs read 0 before the next clock edge; after release, a new start completes normally.
